// File: rtl/aes_host_sequencer.sv
// -----------------------------------------------------------------------------
// aes_host_sequencer
//   Upstream command stage for the AES core. Takes one request (mode, key,
//   block) over valid/ready. It drives the core's address/data_in bus through
//   config -> key -> init -> block -> next, then polls status. It reads the 16
//   result bytes from data_out and returns the 128-bit result over valid/ready.
//
// Parameters
//   TIMEOUT_CYCLES  poll cycles in WRDY/WVLD before an abort (timeout build only)
//   RD_LAT          cycles from aes_address=RESULT to first valid result byte
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         request handshake (ready only in IDLE)
//   cmd_encdec, cmd_keylen      1=encrypt / 0=decrypt, 0=AES-128 / 1=AES-256
//   cmd_key[255:0]              key, MSB first (AES-128 uses [255:128])
//   cmd_block[127:0]            input block, MSB first
//   res_valid/res_ready         result handshake, result held until accepted
//   res_data[127:0]             result, byte0 = [127:120]
//   res_err                     1 = operation aborted by poll timeout
//   busy                        high in every state except IDLE
//   aes_address, aes_data_in    command bus to the AES core
//   aes_data_out                status / result byte from the AES core
//
// Configuration macro
//   AES_SEQ_TIMEOUT_EN  defined: a 16-bit poll counter aborts WRDY/WVLD after
//                       TIMEOUT_CYCLES cycles (res_err=1, res_data=0).
//                       undefined: polls wait forever, res_err is tied 0.
// -----------------------------------------------------------------------------
module aes_host_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RD_LAT         = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_encdec,
   input  logic         cmd_keylen,
   input  logic [255:0] cmd_key,
   input  logic [127:0] cmd_block,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_data,
   output logic         res_err,
   output logic         busy,
   output logic [3:0]   aes_address,
   output logic [15:0]  aes_data_in,
   input  logic [7:0]   aes_data_out
);

   localparam int RD_CYCLES = 16 + RD_LAT;
   localparam int RD_W      = $clog2(RD_CYCLES);
   localparam logic [RD_W-1:0] RD_FIRST = RD_W'(RD_LAT);
   localparam logic [RD_W-1:0] RD_LAST  = RD_W'(RD_CYCLES - 1);

   localparam logic [3:0] ADDR_IDLE   = 4'h0;
   localparam logic [3:0] ADDR_CFG    = 4'h1;
   localparam logic [3:0] ADDR_KEY    = 4'h2;
   localparam logic [3:0] ADDR_BLOCK  = 4'h3;
   localparam logic [3:0] ADDR_STATUS = 4'h5;
   localparam logic [3:0] ADDR_CTRL   = 4'h6;
   localparam logic [3:0] ADDR_RESULT = 4'h7;

   typedef enum logic [3:0] {
      S_IDLE, S_CFG, S_KEY, S_INIT, S_WRDY, S_BLK, S_NEXT, S_WVLD, S_READ, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [RD_W-1:0] rcnt_q, rcnt_d;
   logic            keylen_q;
   logic [255:0]    key_q;
   logic [127:0]    block_q;
   logic [127:0]    res_data_q;
   logic [3:0]      addr_q, addr_d;
   logic [15:0]     din_q, din_d;
   logic            cmd_ready_q, busy_q, res_valid_q;
   logic            handshake;
   logic            poll_expired;
   logic [3:0]      key_last;

   // Word views of the latched key/block; word 0 is the most significant.
   logic [15:0] key_words [16];
   logic [15:0] blk_words [8];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_key_words
         assign key_words[gi] = key_q[255-16*gi -: 16];
      end
      for (gi = 0; gi < 8; gi++) begin : g_blk_words
         assign blk_words[gi] = block_q[127-16*gi -: 16];
      end
   endgenerate

   assign handshake = cmd_valid && cmd_ready_q;
   assign key_last  = keylen_q ? 4'd15 : 4'd7;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         S_IDLE: if (handshake) state_d = S_CFG;
         S_CFG:  state_d = S_KEY;
         S_KEY: begin
            if (wcnt_q == key_last) state_d = S_INIT;
            else                    wcnt_d  = wcnt_q + 4'd1;
         end
         S_INIT: state_d = S_WRDY;
         S_WRDY: begin
            if (aes_data_out[0])   state_d = S_BLK;
            else if (poll_expired) state_d = S_DONE;
         end
         S_BLK: begin
            if (wcnt_q == 4'd7) state_d = S_NEXT;
            else                wcnt_d  = wcnt_q + 4'd1;
         end
         S_NEXT: state_d = S_WVLD;
         S_WVLD: begin
            if (aes_data_out[1])   state_d = S_READ;
            else if (poll_expired) state_d = S_DONE;
         end
         S_READ: begin
            if (rcnt_q == RD_LAST) state_d = S_DONE;
            else                   rcnt_d  = rcnt_q + 1'b1;
         end
         S_DONE: if (res_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Counters restart on every state entry so each state sees word 0 first.
      if (state_d != state_q) begin
         wcnt_d = '0;
         rcnt_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode from the next state, so the bus is registered and lines up
   // with the state it belongs to. CFG is only ever entered on the handshake
   // edge, so its data comes straight from the request inputs.
   // ---------------------------------------------------------------------------
   always_comb begin
      addr_d = ADDR_IDLE;
      din_d  = 16'h0000;
      case (state_d)
         S_CFG: begin
            addr_d = ADDR_CFG;
            din_d  = {14'b0, cmd_keylen, cmd_encdec};
         end
         S_KEY: begin
            addr_d = ADDR_KEY;
            din_d  = key_words[wcnt_d];
         end
         S_INIT: begin
            addr_d = ADDR_CTRL;
            din_d  = 16'h0001;
         end
         S_WRDY: addr_d = ADDR_STATUS;
         S_BLK: begin
            addr_d = ADDR_BLOCK;
            din_d  = blk_words[wcnt_d[2:0]];
         end
         S_NEXT: begin
            addr_d = ADDR_CTRL;
            din_d  = 16'h0002;
         end
         S_WVLD: addr_d = ADDR_STATUS;
         S_READ: addr_d = ADDR_RESULT;
         default: begin
            addr_d = ADDR_IDLE;
            din_d  = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         keylen_q    <= 1'b0;
         key_q       <= '0;
         block_q     <= '0;
         res_data_q  <= '0;
         addr_q      <= ADDR_IDLE;
         din_q       <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         cmd_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         res_valid_q <= (state_d == S_DONE);
         if (handshake) begin
            keylen_q <= cmd_keylen;
            key_q    <= cmd_key;
            block_q  <= cmd_block;
         end
         // Bytes arrive MSB first; shifting them in leaves byte0 at the top.
         if (state_q == S_READ && rcnt_q >= RD_FIRST) begin
            res_data_q <= {res_data_q[119:0], aes_data_out};
         end else if (state_d == S_DONE && (state_q == S_WRDY || state_q == S_WVLD)) begin
            res_data_q <= '0;
         end
      end
   end

`ifdef AES_SEQ_TIMEOUT_EN
   logic [15:0] poll_q, poll_d;
   logic        err_q;

   // The count equals the number of completed poll cycles in this state.
   assign poll_expired = (poll_q == 16'(TIMEOUT_CYCLES - 1));

   always_comb begin
      poll_d = '0;
      if (state_d == state_q && (state_q == S_WRDY || state_q == S_WVLD)) begin
         poll_d = poll_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_q <= '0;
         err_q  <= 1'b0;
      end else begin
         poll_q <= poll_d;
         // Any entry into DONE other than from READ is an abort.
         if (state_d == S_DONE && state_q != S_DONE) begin
            err_q <= (state_q != S_READ);
         end
      end
   end

   assign res_err = err_q;
`else
   // No abort path: polls wait indefinitely. The parameter stays referenced so
   // both builds share one interface; a non-positive limit is meaningless.
   assign poll_expired = (TIMEOUT_CYCLES < 1);
   assign res_err      = 1'b0;
`endif

   assign cmd_ready   = cmd_ready_q;
   assign busy        = busy_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign aes_address = addr_q;
   assign aes_data_in = din_q;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_host_sequencer
//   Self-checking bench for aes_host_sequencer. A behavioural AES-core model
//   captures the bus writes, answers status polls after a programmable delay
//   and streams a result computed from what it received. Expected results,
//   latencies and write counts come from the request alone.
// -----------------------------------------------------------------------------
module tb_aes_host_sequencer;

   localparam int RD_LAT = 1;
   localparam int TMO    = 16;
`ifdef AES_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid, cmd_ready, cmd_encdec, cmd_keylen;
   logic [255:0] cmd_key;
   logic [127:0] cmd_block;
   logic         res_valid, res_ready, res_err, busy;
   logic [127:0] res_data;
   logic [3:0]   aes_address;
   logic [15:0]  aes_data_in;
   logic [7:0]   aes_data_out;

   aes_host_sequencer #(.TIMEOUT_CYCLES(TMO), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_encdec(cmd_encdec), .cmd_keylen(cmd_keylen),
      .cmd_key(cmd_key), .cmd_block(cmd_block),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err), .busy(busy),
      .aes_address(aes_address), .aes_data_in(aes_data_in),
      .aes_data_out(aes_data_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stand-in for the cipher: the two known-answer vectors give their real
   // ciphertexts, anything else a cheap mix of every key and block bit.
   function automatic logic [127:0] aes_ref(input logic kl, input logic ed,
                                            input logic [255:0] key, input logic [127:0] blk);
      if (!kl && ed && key == {K128, 128'h0} && blk == PT) return CT128;
      if (kl && ed && key == K256 && blk == PT) return CT256;
      return blk ^ key[255:128] ^ {key[126:0], key[127]} ^ {blk[62:0], blk[127:63]}
             ^ ({128{ed}} & 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3);
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   // ---------------- AES core model + bus monitor ----------------
   logic [15:0]  cfg_cap = '0;
   logic [255:0] key_cap = '0;
   logic [127:0] blk_cap = '0;
   logic [127:0] core_result = '0;
   logic         core_rdy = 1'b0, core_vld = 1'b0;
   int           rdy_left = 0, vld_left = 0, rd_cnt = 0;
   int           rdy_delay = 0, vld_delay = 0;
   bit           rdy_never = 1'b0;
   int           mon_key_cnt = 0;
   bit           early_read = 1'b0, bad_din = 1'b0;

   always @(posedge clk) begin
      if (aes_address == 4'h1) begin
         cfg_cap     <= aes_data_in;
         key_cap     <= '0;
         blk_cap     <= '0;
         mon_key_cnt <= 0;
         early_read  <= 1'b0;
      end
      if (aes_address == 4'h2) begin
         key_cap     <= {key_cap[239:0], aes_data_in};
         mon_key_cnt <= mon_key_cnt + 1;
      end
      if (aes_address == 4'h3) blk_cap <= {blk_cap[111:0], aes_data_in};
      if (aes_address == 4'h6 && aes_data_in == 16'h0001) begin
         core_rdy <= (rdy_delay == 0) && !rdy_never;
         rdy_left <= rdy_delay;
      end else if (!core_rdy && !rdy_never && rdy_left > 0) begin
         rdy_left <= rdy_left - 1;
         if (rdy_left == 1) core_rdy <= 1'b1;
      end
      if (aes_address == 4'h6 && aes_data_in == 16'h0002) begin
         core_vld    <= (vld_delay == 0);
         vld_left    <= vld_delay;
         core_result <= aes_ref(cfg_cap[1], cfg_cap[0],
                                cfg_cap[1] ? key_cap : {key_cap[127:0], 128'h0}, blk_cap);
      end else if (!core_vld && vld_left > 0) begin
         vld_left <= vld_left - 1;
         if (vld_left == 1) core_vld <= 1'b1;
      end
      rd_cnt <= (aes_address == 4'h7) ? rd_cnt + 1 : 0;
      if (aes_address == 4'h7 && !core_vld) early_read <= 1'b1;
      if ((aes_address == 4'h0 || aes_address == 4'h5 || aes_address == 4'h7) && aes_data_in != 16'h0)
         bad_din <= 1'b1;
   end

   logic [127:0] rd_tmp;
   always_comb begin
      aes_data_out = 8'h00;
      rd_tmp       = core_result;
      if (aes_address == 4'h5) begin
         aes_data_out = {6'b0, core_vld, core_rdy};
      end else if (aes_address == 4'h7 && rd_cnt >= RD_LAT && rd_cnt < RD_LAT + 16) begin
         rd_tmp       = core_result << (8 * (rd_cnt - RD_LAT));
         aes_data_out = rd_tmp[127:120];
      end
   end

   // ---------------- transaction driver ----------------
   task automatic start_req(input logic kl, input logic ed, input logic [255:0] key,
                            input logic [127:0] blk, output bit ok);
      int w = 0;
      @(negedge clk);
      cmd_keylen = kl; cmd_encdec = ed; cmd_key = key; cmd_block = blk;
      cmd_valid  = 1'b1;
      while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
      ok = cmd_ready;
      if (!ok) begin
         check_eq("cmd_ready_wait", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Scramble the request lines: the DUT must work from its latched copy.
      cmd_valid = 1'b0;
      cmd_key = rand256(); cmd_block = rand256()[127:0];
      cmd_keylen = ~kl; cmd_encdec = ~ed;
   endtask

   task automatic run_txn(input string name, input logic kl, input logic ed,
                          input logic [255:0] key, input logic [127:0] blk,
                          input int d_rdy, input int d_vld, input bit never, input int hold);
      bit ok, hold_ok, exp_err;
      int lat, exp_lat, klw;
      logic [127:0] exp_res, cap;
      klw = kl ? 16 : 8;
      rdy_delay = d_rdy; vld_delay = d_vld; rdy_never = never;
      if (TMO_EN && (never || d_rdy >= TMO)) begin
         exp_err = 1'b1; exp_lat = 1 + klw + 1 + TMO;
      end else if (TMO_EN && d_vld >= TMO) begin
         exp_err = 1'b1; exp_lat = 1 + klw + 1 + 1 + d_rdy + 8 + 1 + TMO;
      end else begin
         exp_err = 1'b0; exp_lat = 1 + klw + 1 + 1 + d_rdy + 8 + 1 + 1 + d_vld + 16 + RD_LAT;
      end
      exp_res = exp_err ? '0 : aes_ref(kl, ed, kl ? key : {key[255:128], 128'h0}, blk);

      start_req(kl, ed, key, blk, ok);
      if (!ok) return;
      lat = 0;
      while (lat < 3000) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (res_valid) break;
      end
      if (!res_valid) begin
         check_eq({name, "_res_valid_timeout"}, 0, 1);
         return;
      end
      check_eq({name, "_latency"}, 128'(lat), 128'(exp_lat));
      check_eq({name, "_res_data"}, res_data, exp_res);
      check_eq({name, "_res_err"}, 128'(res_err), 128'(exp_err));
      check_eq({name, "_key_writes"}, 128'(mon_key_cnt), 128'(klw));
      check_eq({name, "_cfg_data"}, 128'(cfg_cap), 128'({kl, ed}));
      check_eq({name, "_no_early_read"}, 128'(early_read), 0);
      check_eq({name, "_busy_ready"}, {busy, cmd_ready}, 2'b10);

      // Backpressure: result must hold, further requests must be refused.
      cap = res_data;
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'($urandom);
         cmd_key = rand256();
         @(posedge clk);
         @(negedge clk);
         if (!res_valid || res_data !== cap || cmd_ready || res_err !== exp_err) hold_ok = 1'b0;
      end
      if (hold > 0) check_eq({name, "_hold_stable"}, 128'(hold_ok), 1);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check_eq({name, "_after_accept"}, {res_valid, busy, cmd_ready}, 3'b001);
      check_eq({name, "_idle_din_zero"}, 128'(bad_din), 0);
      $display("txn %s kl=%0d ed=%0d lat=%0d res=%h err=%0d", name, kl, ed, lat, res_data, res_err);
   endtask

   task automatic reset_mid_key();
      bit ok;
      int w = 0;
      rdy_delay = 0; vld_delay = 0; rdy_never = 1'b0;
      start_req(1'b1, 1'b0, rand256(), rand256()[127:0], ok);
      if (!ok) return;
      while (aes_address != 4'h2 && w < 50) begin @(negedge clk); w++; end
      check_eq("rst_reached_key", 128'(aes_address), 4'h2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_ctrl", {cmd_ready, busy, res_valid, res_err}, 4'b0000);
      check_eq("rst_mid_bus", {aes_address, aes_data_in}, 20'h0);
      check_eq("rst_mid_res_data", res_data, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_release_ready", {cmd_ready, busy}, 2'b10);
      $display("txn reset_mid_key done");
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_encdec = 1'b0; cmd_keylen = 1'b0;
      cmd_key = '0; cmd_block = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_ctrl", {cmd_ready, busy, res_valid, res_err}, 4'b0000);
      check_eq("reset_bus", {aes_address, aes_data_in}, 20'h0);
      check_eq("reset_res_data", res_data, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("reset_release_ready", {cmd_ready, busy}, 2'b10);

      run_txn("aes128_kat", 1'b0, 1'b1, {K128, 128'h0}, PT, 0, 0, 1'b0, 0);
      run_txn("aes256_kat", 1'b1, 1'b1, K256, PT, 0, 0, 1'b0, 3);
      run_txn("backpressure", 1'($urandom), 1'($urandom), rand256(), rand256()[127:0], 2, 1, 1'b0, 10);
      run_txn("status_stall", 1'b0, 1'b0, rand256(), rand256()[127:0], 0, 50, 1'b0, 1);
      reset_mid_key();
      run_txn("after_reset", 1'b1, 1'b0, rand256(), rand256()[127:0], 1, 0, 1'b0, 0);
`ifdef AES_SEQ_TIMEOUT_EN
      run_txn("timeout_rdy", 1'b0, 1'b1, rand256(), rand256()[127:0], 0, 0, 1'b1, 2);
      run_txn("after_timeout", 1'b0, 1'b1, {K128, 128'h0}, PT, 0, 0, 1'b0, 0);
`endif
      for (int t = 0; t < 20; t++) begin
         run_txn($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), rand256(), rand256()[127:0],
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b0,
                 int'($urandom_range(0, 4)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global guard so a stuck DUT can never hang the run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
